// File: rtl/sobel_pkg.sv
// Shared types and helpers for the sobel 3x3 window generator.
package sobel_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int KPIX_W    = PIX_W_DEF + 1;

  typedef enum logic {
    ACTIVE = 1'b0,
    DONE   = 1'b1
  } state_e;

  // Width of a coordinate counter covering 0..n-1 (never narrower than 1 bit).
  function automatic int coord_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Single-line pixel store. Combinational read of the addressed entry,
// write on the clock edge, so a same-address access returns the old data.
module sobel_line_buf #(
  parameter int DEPTH = 64,
  parameter int W     = 8,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Storage is deliberately not reset; rows are only consumed once rewritten.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream -> sliding 3x3 interior window for the sobel kernel.
// Two line buffers hold rows r-1 and r-2; a 3x3 register window shifts left
// on every accepted pixel. Window registers are [row][col], col 0 = left.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             sof,
  output logic [PIX_W:0]   p0,
  output logic [PIX_W:0]   p1,
  output logic [PIX_W:0]   p2,
  output logic [PIX_W:0]   p3,
  output logic [PIX_W:0]   p5,
  output logic [PIX_W:0]   p6,
  output logic [PIX_W:0]   p7,
  output logic [PIX_W:0]   p8,
  output logic             win_valid,
  output logic             frame_done,
  output logic             err_overrun
);

  localparam int KW = PIX_W + 1;
  localparam int CW = coord_w(IMG_W);
  localparam int RW = coord_w(IMG_H);

  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [RW-1:0] R_TWO  = RW'(2);

  state_e                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d, col_eff;
  logic [RW-1:0]            row_q, row_d, row_eff;
  logic [2:0][2:0][KW-1:0]  win_q, win_d;
  logic                     win_valid_q, win_valid_d;
  logic                     frame_done_q, frame_done_d;
  logic                     err_q, err_d;
  logic                     take;
  logic [PIX_W-1:0]         lb1_rd, lb2_rd;

  // sof forces the accepted pixel to (0,0) whatever the counters say.
  assign col_eff = sof ? '0 : col_q;
  assign row_eff = sof ? '0 : row_q;

  // After frame end only a sof pixel is taken; everything else is dropped.
  assign take = pix_valid & (sof | (state_q == ACTIVE));

  sobel_line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb1 (
    .clk     (clk),
    .we_i    (take),
    .addr_i  (col_eff),
    .wdata_i (pix_in),
    .rdata_o (lb1_rd)
  );

  // lb2 receives the row that lb1 is about to overwrite.
  sobel_line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb2 (
    .clk     (clk),
    .we_i    (take),
    .addr_i  (col_eff),
    .wdata_i (lb1_rd),
    .rdata_o (lb2_rd)
  );

  // Next-state: counters, FSM, window shift and output strobes.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err_q;

    if (pix_valid) begin
      if (sof)                   err_d = 1'b0;
      else if (state_q == DONE)  err_d = 1'b1;
    end

    if (take) begin
      state_d = ACTIVE;
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = {1'b0, lb2_rd};
      win_d[1][2] = {1'b0, lb1_rd};
      win_d[2][2] = {1'b0, pix_in};
      win_valid_d = (row_eff >= R_TWO) && (col_eff >= C_TWO);

      if (col_eff == C_LAST) begin
        col_d = '0;
        if (row_eff == R_LAST) begin
          row_d        = '0;
          state_d      = DONE;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_eff + RW'(1);
        end
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end
  end

  // State register; line buffers are excluded from reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACTIVE;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // Centre win_q[1][1] is kept only to feed p3 on the next shift.
  assign p0          = win_q[0][0];
  assign p1          = win_q[0][1];
  assign p2          = win_q[0][2];
  assign p3          = win_q[1][0];
  assign p5          = win_q[1][2];
  assign p6          = win_q[2][0];
  assign p7          = win_q[2][1];
  assign p8          = win_q[2][2];
  assign win_valid   = win_valid_q;
  assign frame_done  = frame_done_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench: two DUTs (4x4 and 5x4). The driver feeds a frame-image
// reference model that pushes expected windows; negedge monitors pop/compare.
module tb_sobel_window_gen;

  typedef struct packed {
    logic [8:0] p0, p1, p2, p3, p5, p6, p7, p8;
  } win_t;

  localparam logic [71:0] W1  = {9'h000, 9'h001, 9'h002, 9'h010,
                                 9'h012, 9'h020, 9'h021, 9'h022};
  localparam logic [71:0] WFF = {8{9'h0FF}};

  logic clk = 1'b0;
  logic rst_n;
  logic va, sa, vb, sb;
  logic [7:0] pa, pb;
  logic [7:0][8:0] ap, bp;
  logic a_wv, a_fd, a_err, b_wv, b_fd, b_err;
  logic accp_a, accp_b;
  win_t obs_a, obs_b;

  always #5 clk = ~clk;

  sobel_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .pix_valid(va), .pix_in(pa), .sof(sa),
    .p0(ap[0]), .p1(ap[1]), .p2(ap[2]), .p3(ap[3]),
    .p5(ap[4]), .p6(ap[5]), .p7(ap[6]), .p8(ap[7]),
    .win_valid(a_wv), .frame_done(a_fd), .err_overrun(a_err)
  );

  sobel_window_gen #(.IMG_W(5), .IMG_H(4), .PIX_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .pix_valid(vb), .pix_in(pb), .sof(sb),
    .p0(bp[0]), .p1(bp[1]), .p2(bp[2]), .p3(bp[3]),
    .p5(bp[4]), .p6(bp[5]), .p7(bp[6]), .p8(bp[7]),
    .win_valid(b_wv), .frame_done(b_fd), .err_overrun(b_err)
  );

  assign obs_a = {ap[0], ap[1], ap[2], ap[3], ap[4], ap[5], ap[6], ap[7]};
  assign obs_b = {bp[0], bp[1], bp[2], bp[3], bp[4], bp[5], bp[6], bp[7]};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the frame as an image plus a raster position.
  int         m_r[2], m_c[2];
  bit         m_done[2], m_err[2];
  logic [7:0] img[2][4][5];
  int         mw[2] = '{4, 5};
  win_t       qa[$], qb[$];

  // Monitor bookkeeping.
  int   win_cnt[2], fd_cnt[2];
  win_t first_obs[2], last_exp[2];
  bit   hold[2];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_r[i] = 0; m_c[i] = 0; m_done[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_step(input int id, input logic [7:0] px, input logic s);
    win_t e;
    int r, c;
    if (s) begin
      m_r[id] = 0; m_c[id] = 0; m_done[id] = 0; m_err[id] = 0;
    end else if (m_done[id]) begin
      m_err[id] = 1;
      return;
    end
    r = m_r[id];
    c = m_c[id];
    img[id][r][c] = px;
    if (r >= 2 && c >= 2) begin
      e.p0 = {1'b0, img[id][r-2][c-2]};
      e.p1 = {1'b0, img[id][r-2][c-1]};
      e.p2 = {1'b0, img[id][r-2][c]};
      e.p3 = {1'b0, img[id][r-1][c-2]};
      e.p5 = {1'b0, img[id][r-1][c]};
      e.p6 = {1'b0, img[id][r][c-2]};
      e.p7 = {1'b0, img[id][r][c-1]};
      e.p8 = {1'b0, img[id][r][c]};
      if (id == 0) qa.push_back(e);
      else         qb.push_back(e);
    end
    m_c[id]++;
    if (m_c[id] == mw[id]) begin
      m_c[id] = 0;
      m_r[id]++;
      if (m_r[id] == 4) begin
        m_r[id] = 0;
        m_done[id] = 1;
      end
    end
  endtask

  task automatic mon(input int id, input win_t obs, input logic wv,
                     input logic fd, input logic acc);
    win_t e;
    int   qs;
    if (fd) fd_cnt[id]++;
    if (wv) begin
      chk("win_needs_accept", {71'b0, acc}, 72'd1);
      qs = (id == 0) ? qa.size() : qb.size();
      if (qs == 0) begin
        chk("unexpected_win", 72'd1, 72'd0);
      end else begin
        if (id == 0) e = qa.pop_front();
        else         e = qb.pop_front();
        chk("win", obs, e);
        if (win_cnt[id] == 0) first_obs[id] = obs;
        win_cnt[id]++;
        last_exp[id] = e;
        hold[id] = 1;
      end
    end else if (acc) begin
      hold[id] = 0;
    end else if (hold[id]) begin
      chk("hold", obs, last_exp[id]);
    end
  endtask

  always @(posedge clk) begin
    accp_a <= va;
    accp_b <= vb;
  end

  always @(negedge clk) if (rst_n) mon(0, obs_a, a_wv, a_fd, accp_a);
  always @(negedge clk) if (rst_n) mon(1, obs_b, b_wv, b_fd, accp_b);

  task automatic idle();
    @(posedge clk); #1;
    va = 1'b0; vb = 1'b0;
    pa = 8'($urandom); pb = 8'($urandom);
    sa = 1'($urandom); sb = 1'($urandom);
  endtask

  task automatic send(input int id, input logic [7:0] px, input logic s);
    @(posedge clk); #1;
    if (id == 0) begin
      va = 1'b1; pa = px; sa = s; vb = 1'b0; sb = 1'($urandom);
    end else begin
      vb = 1'b1; pb = px; sb = s; va = 1'b0; sa = 1'($urandom);
    end
    model_step(id, px, s);
  endtask

  task automatic frame(input int id, input bit gaps, input bit allff);
    logic [7:0] px;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < mw[id]; c++) begin
        px = allff ? 8'hFF : 8'(16 * r + c);
        send(id, px, (r == 0 && c == 0));
        if (gaps && $urandom_range(0, 1) == 1)
          repeat ($urandom_range(1, 3)) idle();
      end
  endtask

  task automatic end_scen(input int id, input int nwin, input int nfd);
    int qs;
    repeat (3) idle();
    qs = (id == 0) ? qa.size() : qb.size();
    chk("win_count", nwin, win_cnt[id]);
    chk("frame_done_count", fd_cnt[id], nfd);
    chk("queue_empty", qs, 0);
    win_cnt[id] = 0;
    fd_cnt[id]  = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    va = 0; vb = 0; sa = 0; sb = 0; pa = 0; pb = 0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      win_cnt[i] = 0; fd_cnt[i] = 0; hold[i] = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wv_a", a_wv, 0);   chk("rst_p_a", obs_a, 0);
    chk("rst_fd_a", a_fd, 0);   chk("rst_err_a", a_err, 0);
    chk("rst_wv_b", b_wv, 0);   chk("rst_p_b", obs_b, 0);
    rst_n = 1'b1;

    // 1: continuous 4x4 frame
    frame(0, 0, 0);
    end_scen(0, 4, 1);
    chk("s1_first_win", first_obs[0], W1);

    // 2: same frame with random gaps
    frame(0, 1, 0);
    end_scen(0, 4, 1);
    chk("s2_first_win", first_obs[0], W1);

    // 3: overrun after frame end, then recovery
    send(0, 8'h55, 1'b0);
    idle();
    send(0, 8'h66, 1'b0);
    repeat (3) idle();
    chk("s3_no_win", win_cnt[0], 0);
    chk("s3_err_set", a_err, 1);
    chk("s3_err_model", a_err, m_err[0]);
    frame(0, 1, 0);
    chk("s3_err_clear", a_err, 0);
    end_scen(0, 4, 1);
    chk("s3_first_win", first_obs[0], W1);

    // 4: sof arrives at (2,1) of a partial frame
    for (int i = 0; i < 9; i++) send(0, 8'(16 * (i / 4) + i % 4), (i == 0));
    frame(0, 0, 0);
    end_scen(0, 4, 1);
    chk("s4_first_win", first_obs[0], W1);

    // 5: reset while the (2,2) window is being presented
    for (int i = 0; i < 11; i++) send(0, 8'(16 * (i / 4) + i % 4), (i == 0));
    @(posedge clk); #1;
    rst_n = 1'b0; va = 1'b0; vb = 1'b0;
    #1;
    chk("s5_rst_wv", a_wv, 0);
    chk("s5_rst_p", obs_a, 0);
    chk("s5_rst_fd", a_fd, 0);
    qa.delete(); qb.delete();
    hold[0] = 0; hold[1] = 0;
    model_reset();
    repeat (2) idle();
    rst_n = 1'b1;
    frame(0, 0, 0);
    end_scen(0, 4, 1);
    chk("s5_first_win", first_obs[0], W1);

    // 6: all-0xFF frame on the 5-wide instance
    frame(1, 1, 1);
    end_scen(1, 6, 1);
    chk("s6_first_win", first_obs[1], WFF);
    chk("s6_err", b_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
